// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: parity-checking FWFT receive FIFO with sticky overflow and saturating parity-error count
module uart_rx_buffer #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = 4,
  parameter bit PARITY_ODD = 0,
  parameter bit DROP_BAD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_in,
  input  logic              parity_in,
  input  logic              data_valid,
  input  logic              rd_en,
  input  logic              clr_err,
  output logic [7:0]        rd_data,
  output logic              rd_parity_err,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow_err,
  output logic [7:0]        parity_err_cnt
);
  logic [8:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_ovf;
  logic [7:0]        r_pcnt;
  logic              w_perr, w_pe_evt, w_pop, w_keep, w_store, w_lost;
  assign w_perr = (^data_in) ^ parity_in ^ PARITY_ODD;
  assign w_pe_evt = data_valid & w_perr;
  assign empty = r_count == '0;
  assign full = r_count == (ADDR_W+1)'(DEPTH);
  assign w_pop = rd_en & ~empty;
  assign w_keep = data_valid & ~(DROP_BAD & w_perr);
  assign w_store = w_keep & (~full | w_pop);
  assign w_lost = w_keep & full & ~w_pop;
  assign rd_data = empty ? 8'h00 : r_mem[r_rptr][7:0];
  assign rd_parity_err = ~empty & r_mem[r_rptr][8];
  assign count = r_count;
  assign overflow_err = r_ovf;
  assign parity_err_cnt = r_pcnt;
  // storage array is deliberately left unreset; empty masking hides stale contents
  always_ff @(posedge clk)
    if (w_store && !rst) r_mem[r_wptr] <= {w_perr, data_in};
  // pointers and occupancy; a store and pop together leave count unchanged
  always_ff @(posedge clk)
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_store) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + {{ADDR_W{1'b0}}, w_store} - {{ADDR_W{1'b0}}, w_pop};
    end
  // error status; a fresh event in the clearing cycle takes priority over the clear
  always_ff @(posedge clk)
    if (rst) begin
      r_ovf  <= 1'b0;
      r_pcnt <= '0;
    end else begin
      r_ovf  <= w_lost | (r_ovf & ~clr_err);
      r_pcnt <= clr_err ? {7'b0, w_pe_evt} : (w_pe_evt && r_pcnt != 8'hFF) ? r_pcnt + 8'd1 : r_pcnt;
    end
endmodule

// File: tb/tb_uart_rx_buffer.sv
// tb_uart_rx_buffer: scoreboard bench for keep-bad and drop-bad builds driven with identical stimulus
module tb_uart_rx_buffer;
  localparam int DEPTH = 16;
  localparam int AW = 4;
  localparam bit PODD = 0;
  logic clk = 0, rst = 1, dv = 0, par = 0, rd = 0, clr = 0;
  logic [7:0] din = 0;
  logic [7:0] rdd [2];
  logic [7:0] pcnt [2];
  logic rpe [2], emp [2], ful [2], ovf [2];
  logic [AW:0] cnt [2];
  int n_chk = 0, n_err = 0;
  logic [8:0] exb [2][4096];
  int hd [2], tl [2], m_cnt [2], m_pe [2];
  bit m_ovf [2];

  uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .PARITY_ODD(PODD), .DROP_BAD(0)) u_keep (
    .clk(clk), .rst(rst), .data_in(din), .parity_in(par), .data_valid(dv), .rd_en(rd), .clr_err(clr),
    .rd_data(rdd[0]), .rd_parity_err(rpe[0]), .empty(emp[0]), .full(ful[0]), .count(cnt[0]),
    .overflow_err(ovf[0]), .parity_err_cnt(pcnt[0]));
  uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .PARITY_ODD(PODD), .DROP_BAD(1)) u_drop (
    .clk(clk), .rst(rst), .data_in(din), .parity_in(par), .data_valid(dv), .rd_en(rd), .clr_err(clr),
    .rd_data(rdd[1]), .rd_parity_err(rpe[1]), .empty(emp[1]), .full(ful[1]), .count(cnt[1]),
    .overflow_err(ovf[1]), .parity_err_cnt(pcnt[1]));

  always #5 clk = ~clk;

  task automatic chk(string nm, int k, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d act=%0h exp=%0h", nm, k, act, exp);
    end
  endtask

  function automatic bit gp(logic [7:0] d);
    return (^d) ^ PODD;
  endfunction

  // monitor: whenever a DUT accepts a pop, its head must equal the oldest expected entry
  always @(negedge clk)
    if (!rst && rd)
      for (int k = 0; k < 2; k++)
        if (!emp[k]) begin
          if (hd[k] == tl[k]) begin
            n_chk++;
            n_err++;
            $display("FAIL pop_extra dut%0d act=%0h exp=none", k, {rpe[k], rdd[k]});
          end else begin
            chk("pop_data", k, int'({rpe[k], rdd[k]}), int'(exb[k][hd[k] % 4096]));
            hd[k]++;
          end
        end

  task automatic step(bit v, logic [7:0] d, bit p, bit r, bit c, bit rs = 0);
    bit pe, pop, keep, store, lost;
    dv = v; din = d; par = p; rd = r; clr = c; rst = rs;
    pe = (^d) ^ p ^ PODD;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rs) begin
        m_cnt[k] = 0; m_pe[k] = 0; m_ovf[k] = 0; tl[k] = hd[k];
      end else begin
        pop = r && m_cnt[k] > 0;
        keep = v && !(k == 1 && pe);
        store = keep && (m_cnt[k] < DEPTH || pop);
        lost = keep && m_cnt[k] == DEPTH && !pop;
        if (store) begin
          exb[k][tl[k] % 4096] = {pe, d};
          tl[k]++;
        end
        m_cnt[k] += int'(store) - int'(pop);
        m_ovf[k] = lost || (m_ovf[k] && !c);
        m_pe[k] = c ? int'(v && pe) : (v && pe && m_pe[k] < 255) ? m_pe[k] + 1 : m_pe[k];
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("count", k, int'(cnt[k]), m_cnt[k]);
      chk("empty", k, int'(emp[k]), int'(m_cnt[k] == 0));
      chk("full", k, int'(ful[k]), int'(m_cnt[k] == DEPTH));
      chk("overflow", k, int'(ovf[k]), int'(m_ovf[k]));
      chk("perr_cnt", k, int'(pcnt[k]), m_pe[k]);
      if (m_cnt[k] == 0) chk("empty_head", k, int'({rpe[k], rdd[k]}), 0);
      else chk("head", k, int'({rpe[k], rdd[k]}), int'(exb[k][hd[k] % 4096]));
    end
  endtask

  initial begin
    logic [7:0] d;
    for (int k = 0; k < 2; k++) begin
      hd[k] = 0; tl[k] = 0; m_cnt[k] = 0; m_pe[k] = 0; m_ovf[k] = 0;
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(1, 8'hA5, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 8'h01, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    repeat (300) begin
      d = 8'($urandom);
      step(1, d, ~gp(d), 1, 0);
    end
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i), gp(8'(i)), 0, 0);
    step(1, 8'h55, gp(8'h55), 0, 0);
    repeat (17) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(1, 8'(i + 32), gp(8'(i + 32)), 0, 0);
    step(1, 8'h77, gp(8'h77), 1, 0);
    repeat (17) step(0, 0, 0, 1, 0);
    step(1, 8'h3C, gp(8'h3C), 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 8'hC3, ~gp(8'hC3), 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 8'(i + 64), gp(8'(i + 64)), 0, 0);
    step(1, 8'h99, 0, 1, 1, 1);
    step(0, 0, 0, 0, 0);
    for (int i = 0; i < 16; i++) step(1, 8'(i + 96), gp(8'(i + 96)), 0, 0);
    step(1, 8'h55, gp(8'h55), 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      d = 8'($urandom);
      step($urandom_range(0, 9) < 6, d, $urandom_range(0, 9) < 2 ? ~gp(d) : gp(d),
           $urandom_range(0, 9) < ((i / 200) % 2 ? 8 : 3), $urandom_range(0, 99) < 3,
           $urandom_range(0, 999) < 3);
    end
    repeat (20) step(0, 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
